// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM, and buffers {instr, pc} pairs in a small queue that
// decode drains over a valid/ready handshake. Redirects from execute
// flush the queue and reload the PC.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched/perf_stall
// counters and their output ports.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic [31:0]       id_pc_plus4
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      instr_q [QUEUE_DEPTH];
  logic [31:0]      pc_q    [QUEUE_DEPTH];
  logic             push;
  logic             pop;

  assign imem_addr   = pc[ADDR_W+1:2];
  assign id_valid    = (count != '0);
  assign id_instr    = instr_q[rd_ptr];
  assign id_pc       = pc_q[rd_ptr];
  assign id_pc_plus4 = id_pc + 32'd4;

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign pop  = id_valid && id_ready;
  assign push = fetch_en && !redirect_valid && ((count < DEPTH_C) || pop);

  // Queue storage: written at the write pointer on every push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr] <= imem_instr;
      pc_q[wr_ptr]    <= pc;
    end
  end

  // PC, pointers and occupancy; a redirect overrides everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~32'd3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Fetch and stall counters; a stall is a wanted fetch blocked by a full queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (fetch_en && !redirect_valid && !push) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
